// File: rtl/compare_arbiter_if.sv
// rtl/compare_arbiter_if.sv - request/operand and grant/result bundle for compare_arbiter
interface compare_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] a_flat;
    logic [NREQ*DW-1:0] b_flat;
    logic [NREQ-1:0]    gnt;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic               gt;
    logic               lt;
    logic               eq;
    logic               busy;

    modport master (
        output req, a_flat, b_flat,
        input  gnt, rsp_valid, rsp_id, gt, lt, eq, busy
    );

    modport slave (
        input  req, a_flat, b_flat,
        output gnt, rsp_valid, rsp_id, gt, lt, eq, busy
    );
endinterface

// File: rtl/compare_arbiter.sv
// rtl/compare_arbiter.sv - round-robin shared magnitude comparator; CMP_SIGNED_EN selects signed compare
module compare_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    compare_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] last_id;
    logic [IDW-1:0] cur_id;
    logic [DW-1:0]  op_a;
    logic [DW-1:0]  op_b;

    logic           found;
    logic [IDW-1:0] win;
    int             idx;

    // First set request at or after last_id+1, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(last_id) + 1 + i) % NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    logic cmp_gt;
    logic cmp_lt;

    always_comb begin
`ifdef CMP_SIGNED_EN
        cmp_gt = $signed(op_a) > $signed(op_b);
        cmp_lt = $signed(op_a) < $signed(op_b);
`else
        cmp_gt = op_a > op_b;
        cmp_lt = op_a < op_b;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last_id       <= IDW'(NREQ - 1);
            cur_id        <= '0;
            op_a          <= '0;
            op_b          <= '0;
            bus.gnt       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.gt        <= 1'b0;
            bus.lt        <= 1'b0;
            bus.eq        <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.gnt       <= '0;
                    bus.rsp_valid <= 1'b0;
                    if (found) begin
                        state        <= GRANT;
                        cur_id       <= win;
                        op_a         <= bus.a_flat[int'(win)*DW +: DW];
                        op_b         <= bus.b_flat[int'(win)*DW +: DW];
                        bus.gnt      <= NREQ'(1) << win;
                        bus.busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    state         <= RESP;
                    bus.gnt       <= '0;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_id    <= cur_id;
                    last_id       <= cur_id;
                    bus.gt        <= cmp_gt;
                    bus.lt        <= cmp_lt;
                    bus.eq        <= !cmp_gt && !cmp_lt;
                end
                RESP: begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    bus.gnt       <= '0;
                    bus.rsp_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule
